// File: rtl/bconv_kxk_stream_if.sv
// Column-stream, serial-weight and result signals of the binary-weight KxK convolution engine.
interface bconv_kxk_stream_if #(
    parameter int K  = 5,
    parameter int DW = 32,
    parameter int OW = 32,
    parameter int NW = 8
);
    logic [NW-1:0]   cfg_ni;
    logic            in_valid;
    logic            in_ready;
    logic [K*DW-1:0] in_data;
    logic            in_last;
    logic            w_valid;
    logic            w_bit;
    logic            w_commit;
    logic            w_full;
    logic            out_valid;
    logic [OW-1:0]   out_data;
    logic            done;

    modport master (
        output cfg_ni, in_valid, in_data, in_last, w_valid, w_bit, w_commit,
        input  in_ready, w_full, out_valid, out_data, done
    );

    modport slave (
        input  cfg_ni, in_valid, in_data, in_last, w_valid, w_bit, w_commit,
        output in_ready, w_full, out_valid, out_data, done
    );
endinterface

// File: rtl/bconv_kxk_stream.sv
// Binary-weight KxK convolution over a column stream: double-buffered serial weights,
// pipelined adder tree and saturating output, with valid/ready and column tracking.
module bconv_kxk_stream #(
    parameter int K  = 5,
    parameter int DW = 32,
    parameter int OW = 32,
    parameter int NW = 8
) (
    input  logic              clk,
    input  logic              rst,
    bconv_kxk_stream_if.slave bus
);
    localparam int KK   = K * K;
    localparam int L    = $clog2(KK);
    localparam int NPAD = 1 << L;
    localparam int ACCW = DW + 1 + L;
    localparam int LAT  = 2 + L;
    localparam int CW   = $clog2(KK + 1);
    localparam int DCW  = $clog2(LAT);

    // state | meaning
    // IDLE  | waiting for the first beat of a frame; weight commits apply at once
    // RUN   | frame in progress; commits are deferred to the end of the frame
    // DRAIN | input blocked while the last results leave the pipeline
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NW-1:0]          r_ni;
    logic [NW-1:0]          r_col;
    logic [DCW-1:0]         r_dcnt;
    logic [KK-1:0]          r_w_act;
    logic [KK-1:0]          r_w_shd;
    logic [CW-1:0]          r_w_cnt;
    logic                   r_pending;
    logic [K*DW-1:0]        r_win [K-1];
    logic signed [ACCW-1:0] r_node [1:2*NPAD-1];
    logic [L:0]             r_v;
    logic                   r_out_valid;
    logic [OW-1:0]          r_out_data;

    logic                   w_in_ready, w_beat, w_full, w_commit_ok, w_copy;
    logic                   w_drain_end, w_done, w_col_ok;
    logic [NW-1:0]          w_ni, w_col_cur;
    logic [K*DW-1:0]        w_cols [K];
    logic signed [DW-1:0]   w_px;
    logic signed [ACCW-1:0] w_prod [KK];
    logic [OW-1:0]          w_sat;

    assign w_in_ready  = (r_state != DRAIN);
    assign w_beat      = bus.in_valid & w_in_ready;
    assign w_full      = (r_w_cnt == CW'(KK));
    assign w_commit_ok = w_full & bus.w_commit;
    assign w_drain_end = (r_state == DRAIN) && (r_dcnt == DCW'(LAT - 1));
    assign w_copy      = (w_commit_ok && r_state == IDLE) || ((r_pending || w_commit_ok) && w_drain_end);
    assign w_ni        = (r_state == IDLE) ? bus.cfg_ni : r_ni;
    assign w_col_cur   = (r_state == IDLE) ? '0 : r_col;
    assign w_col_ok    = (w_col_cur >= NW'(K - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                if (w_beat) w_state_nxt = bus.in_last ? DRAIN : RUN;
            end
            DRAIN: begin
                if (w_drain_end) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ni      <= '0;
            r_col     <= '0;
            r_dcnt    <= '0;
            r_w_act   <= '1;
            r_w_shd   <= '1;
            r_w_cnt   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
            if (w_beat) begin
                r_ni  <= w_ni;
                r_col <= (w_col_cur == w_ni - 1'b1) ? '0 : w_col_cur + 1'b1;
            end
            if (bus.w_valid) r_w_shd <= {bus.w_bit, r_w_shd[KK-1:1]};
            // A bit shifted in on the copy edge already belongs to the next load.
            if (w_copy) begin
                r_w_act <= r_w_shd;
                r_w_cnt <= bus.w_valid ? CW'(1) : '0;
            end else if (bus.w_valid && !w_full) begin
                r_w_cnt <= r_w_cnt + 1'b1;
            end
            if (w_copy) r_pending <= 1'b0;
            else if (w_commit_ok && r_state != IDLE) r_pending <= 1'b1;
        end
    end

    // Window column 0 is the oldest; the live input is the newest column.
    always_comb begin
        w_px = '0;
        for (int c = 0; c < K - 1; c++) w_cols[c] = r_win[c];
        w_cols[K-1] = bus.in_data;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_px = w_cols[c][(K-1-r)*DW +: DW];
                w_prod[r*K+c] = r_w_act[r*K+c] ? ACCW'(w_px) : -ACCW'(w_px);
            end
        end
    end

    generate
        if (OW >= ACCW) begin : g_ext
            assign w_sat = OW'(r_node[1]);
        end else begin : g_clamp
            localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            assign w_sat = (r_node[1] > SMAX) ? SMAX[OW-1:0] :
                           (r_node[1] < SMIN) ? SMIN[OW-1:0] : r_node[1][OW-1:0];
        end
    endgenerate

    // Heap-ordered tree: leaves at NPAD.., root at 1; unused leaves stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K - 1; i++) r_win[i] <= '0;
            for (int i = 1; i < 2 * NPAD; i++) r_node[i] <= '0;
            r_v         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_v <= {r_v[L-1:0], w_beat & w_col_ok};
            if (w_beat) begin
                for (int c = 0; c < K - 2; c++) r_win[c] <= r_win[c+1];
                r_win[K-2] <= bus.in_data;
                for (int i = 0; i < KK; i++) r_node[NPAD+i] <= w_prod[i];
            end
            for (int i = 1; i < NPAD; i++) r_node[i] <= r_node[2*i] + r_node[2*i+1];
            r_out_valid <= r_v[L];
            if (r_v[L]) r_out_data <= w_sat;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.w_full    = w_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.done      = w_done;
endmodule

// File: tb/tb_bconv_kxk_stream.sv
// Scoreboard bench: drivers queue expected results and done cycles, negedge monitors check them.
module tb_bconv_kxk_stream;
    localparam int K = 5, KK = 25, LAT = 7, NW = 8;
    localparam int DWA = 32, OWA = 32, DWB = 16, OWB = 16;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_a[$], q_b[$];
    int   qd_a[$], qd_b[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bconv_kxk_stream_if #(.K(K), .DW(DWA), .OW(OWA), .NW(NW)) if_a ();
    bconv_kxk_stream_if #(.K(K), .DW(DWB), .OW(OWB), .NW(NW)) if_b ();

    bconv_kxk_stream #(.K(K), .DW(DWA), .OW(OWA), .NW(NW)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    bconv_kxk_stream #(.K(K), .DW(DWB), .OW(OWB), .NW(NW)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat(input longint v, input int ow);
        longint hi, lo;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        lo = -(64'sd1 <<< (ow - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic longint pix(input int jj, input int r, input int ramp, input longint pv);
        return ramp ? longint'(jj * 8 + r * 3 - 40) : pv;
    endfunction

    function automatic longint ref_sum(input int j, input logic [KK-1:0] w, input int ow);
        longint s, x;
        s = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                x = pix(j - (K - 1) + c, r, 1, 0);
                s += w[r*K+c] ? x : -x;
            end
        return sat(s, ow);
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if_a.in_ready : if_b.in_ready;
    endfunction

    function automatic logic wfull(input int sel);
        return (sel == 0) ? if_a.w_full : if_b.w_full;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.out_valid) begin
                check("a_out_expected", longint'(q_a.size() > 0), 1);
                if (q_a.size() > 0) begin
                    ea = q_a.pop_front();
                    check("a_out_data", longint'($signed(if_a.out_data)), ea.val);
                    check("a_out_cycle", cyc, ea.cyc);
                end
            end
            if (if_a.done) begin
                check("a_done_expected", longint'(qd_a.size() > 0), 1);
                if (qd_a.size() > 0) check("a_done_cycle", cyc, qd_a.pop_front());
            end
            if (if_b.out_valid) begin
                check("b_out_expected", longint'(q_b.size() > 0), 1);
                if (q_b.size() > 0) begin
                    eb = q_b.pop_front();
                    check("b_out_data", longint'($signed(if_b.out_data)), eb.val);
                    check("b_out_cycle", cyc, eb.cyc);
                end
            end
            if (if_b.done) begin
                check("b_done_expected", longint'(qd_b.size() > 0), 1);
                if (qd_b.size() > 0) check("b_done_cycle", cyc, qd_b.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_col(input int sel, input int j, input int ramp, input longint pv, input logic last);
        logic [K*DWA-1:0] va;
        logic [K*DWB-1:0] vb;
        va = '0;
        vb = '0;
        for (int r = 0; r < K; r++) begin
            va[(K-1-r)*DWA +: DWA] = DWA'(pix(j, r, ramp, pv));
            vb[(K-1-r)*DWB +: DWB] = DWB'(pix(j, r, ramp, pv));
        end
        if (sel == 0) begin
            if_a.in_data = va; if_a.in_valid = 1'b1; if_a.in_last = last;
        end else begin
            if_b.in_data = vb; if_b.in_valid = 1'b1; if_b.in_last = last;
        end
    endtask

    task automatic drive_idle(input int sel);
        if (sel == 0) begin if_a.in_valid = 1'b0; if_a.in_last = 1'b0; end
        else begin if_b.in_valid = 1'b0; if_b.in_last = 1'b0; end
    endtask

    task automatic wait_ready(input int sel);
        int n;
        n = 0;
        while (!rdy(sel) && n < 50) begin n++; tick(); end
        if (n >= 50) check("ready_wait", longint'(rdy(sel)), 1);
    endtask

    task automatic run_frame(input int sel, input int ni, input int ncols, input int ramp,
                             input longint pv, input longint exp_u, input int gap,
                             input logic [KK-1:0] wts);
        exp_t e;
        int   lows;
        if (sel == 0) if_a.cfg_ni = NW'(ni); else if_b.cfg_ni = NW'(ni);
        for (int j = 0; j < ncols; j++) begin
            wait_ready(sel);
            drive_col(sel, j, ramp, pv, j == ncols - 1);
            if (j % ni >= K - 1) begin
                e.val = ramp ? ref_sum(j, wts, (sel == 0) ? OWA : OWB) : exp_u;
                e.cyc = cyc + LAT;
                if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
            end
            if (j == ncols - 1) begin
                if (sel == 0) qd_a.push_back(cyc + LAT); else qd_b.push_back(cyc + LAT);
            end
            tick();
            drive_idle(sel);
            if (j < ncols - 1) for (int g = 0; g < gap; g++) tick();
        end
        lows = 0;
        while (!rdy(sel) && lows < 50) begin lows++; tick(); end
        check((sel == 0) ? "a_ready_low_cycles" : "b_ready_low_cycles", lows, LAT);
        check((sel == 0) ? "a_results_missing" : "b_results_missing",
              (sel == 0) ? q_a.size() + qd_a.size() : q_b.size() + qd_b.size(), 0);
    endtask

    task automatic load_w(input int sel, input logic [KK-1:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin if_a.w_valid = 1'b1; if_a.w_bit = bits[i]; end
            else begin if_b.w_valid = 1'b1; if_b.w_bit = bits[i]; end
            tick();
        end
        if (sel == 0) if_a.w_valid = 1'b0; else if_b.w_valid = 1'b0;
    endtask

    task automatic commit_w(input int sel);
        if (sel == 0) if_a.w_commit = 1'b1; else if_b.w_commit = 1'b1;
        tick();
        if (sel == 0) if_a.w_commit = 1'b0; else if_b.w_commit = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KK-1:0] ones, zeros, alt, pat;
        int n_ov, n_dn;
        ones  = '1;
        zeros = '0;
        pat   = 25'h1A53C7;
        for (int i = 0; i < KK; i++) alt[i] = (i % 2 == 0);
        if_a.cfg_ni = '0; if_a.in_valid = 0; if_a.in_data = '0; if_a.in_last = 0;
        if_a.w_valid = 0; if_a.w_bit = 0; if_a.w_commit = 0;
        if_b.cfg_ni = '0; if_b.in_valid = 0; if_b.in_data = '0; if_b.in_last = 0;
        if_b.w_valid = 0; if_b.w_bit = 0; if_b.w_commit = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", if_a.in_ready, 1);
        check("rst_out_valid", if_a.out_valid, 0);
        check("rst_done", if_a.done, 0);
        check("rst_w_full", if_a.w_full, 0);
        check("rst_out_data", if_a.out_data, 0);
        check("rst_b_in_ready", if_b.in_ready, 1);
        check("rst_b_out_data", if_b.out_data, 0);

        run_frame(0, 5, 5, 0, 1, 25, 0, ones);

        load_w(0, ones, KK);
        check("w_full_after_25", wfull(0), 1);
        commit_w(0);
        check("w_full_after_commit", wfull(0), 0);
        run_frame(0, 28, 28, 0, 1, 25, 0, ones);

        load_w(0, alt, KK);
        commit_w(0);
        run_frame(0, 12, 24, 0, 3, 3, 0, alt);
        run_frame(0, 12, 24, 0, 3, 3, 1, alt);

        load_w(0, pat, KK);
        commit_w(0);
        run_frame(0, 12, 12, 1, 0, 0, 0, pat);
        run_frame(0, 9, 18, 1, 0, 0, 1, pat);

        run_frame(0, 3, 6, 0, 1, 0, 0, pat);
        run_frame(0, 5, 1, 0, 1, 0, 0, pat);

        load_w(0, ones, KK);
        commit_w(0);
        fork
            run_frame(0, 28, 40, 0, 1, 25, 0, ones);
            begin
                repeat (2) tick();
                load_w(0, zeros, KK);
                commit_w(0);
                check("w_full_pending_in_run", wfull(0), 1);
            end
        join
        check("w_full_after_drain", wfull(0), 0);
        run_frame(0, 5, 5, 0, 1, -25, 0, zeros);

        load_w(0, ones, 10);
        check("w_full_partial", wfull(0), 0);
        commit_w(0);
        run_frame(0, 5, 5, 0, 1, -25, 0, zeros);

        run_frame(1, 5, 5, 0, -32768, -32768, 0, ones);
        load_w(1, zeros, KK);
        commit_w(1);
        run_frame(1, 6, 6, 0, -32768, 32767, 0, zeros);

        load_w(0, ones, KK);
        check("w_full_before_rst", wfull(0), 1);
        if_a.cfg_ni = NW'(28);
        for (int j = 0; j < 10; j++) begin
            drive_col(0, j, 0, 1, 1'b0);
            tick();
        end
        drive_idle(0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_ov = 0;
        n_dn = 0;
        for (int i = 0; i < 15; i++) begin
            n_ov += int'(if_a.out_valid);
            n_dn += int'(if_a.done);
            tick();
        end
        check("rst_mid_no_out", n_ov, 0);
        check("rst_mid_no_done", n_dn, 0);
        check("rst_mid_in_ready", if_a.in_ready, 1);
        check("rst_mid_w_full", if_a.w_full, 0);
        run_frame(0, 6, 6, 1, 0, 0, 0, ones);

        repeat (10) tick();
        check("a_queue_empty", q_a.size() + qd_a.size(), 0);
        check("b_queue_empty", q_b.size() + qd_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bconv_kxk_stream.md
Name: bconv_kxk_stream

Overview:
- Parametrised binary-weight KxK convolution engine for the BNN datapath; successor of the fixed 5x5 conv unit.
- Consumes one K-row column of pixels per accepted beat from the line-buffer/window block. Computes sum(±pixel) over a KxK window and emits one result per valid window position.
- Replaces fixed cycle-count timing with valid/ready and column tracking.
- Adds double-buffered serial weight loading and output saturation.

Parameters:
K, 5, kernel size (KxK window, K>=2)
DW, 32, signed input pixel width
OW, 32, signed output width
NW, 8, width of row-length config
ACCW, DW+1+clog2(K*K), internal accumulator width (derived, not overridden)
LAT, 2+clog2(K*K), input-to-output latency in cycles (derived; 7 for K=5)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_ni  in  NW  row width in columns, sampled on frame start
in_valid  in  1  column beat valid
in_ready  out  1  engine accepts column (beat = in_valid & in_ready)
in_data  in  K*DW  column; row 0 in MSBs, row K-1 in LSBs
in_last  in  1  marks final column of frame
w_valid  in  1  shift one weight bit into shadow bank
w_bit  in  1  weight, 1=+1, 0=-1
w_commit  in  1  request shadow->active bank copy
w_full  out  1  shadow bank holds >=K*K new bits
out_valid  out  1  result valid
out_data  out  OW  signed result
done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset values:
  - All outputs 0 except in_ready=1.
  - state=IDLE.
  - Both weight banks all-ones (+1).
  - w_cnt=0, col=0, pending=0.
  - Pipeline valid bits cleared.
- Reset mid-frame: everything clears; no done, no further out_valid.
- Window: K columns of K pixels. The current in_data is the newest column, plus K-1 registered columns. The window shifts only on a beat, so gaps in in_valid stall the window without corrupting results.
- Stage 1 (on beat): p[r][c] = w ? x : -x, computed in ACCW so -(-2^(DW-1)) is exact.
- Stages 2..LAT-1: balanced registered adder tree of clog2(K*K) levels. Odd operands pass through one register per level. The tree advances every cycle with a valid bit, independent of stalls.
- Stage LAT: saturate the ACCW sum to OW: clamp to [-2^(OW-1), 2^(OW-1)-1]; sign-extend if OW>=ACCW. Register into out_data.
- A beat at cycle t produces its result at t+LAT.
- Column counter col:
  - Increments per beat and wraps to 0 after cfg_ni_latched-1.
  - Beat is output-valid iff col >= K-1, giving cfg_ni-K+1 outputs per row.
  - If cfg_ni < K, no outputs are produced, but done still pulses.
- out_data holds its last value when out_valid=0.
- FSM:
  - IDLE: in_ready=1. On first beat, latch cfg_ni, col=0, -> RUN. That beat is processed.
  - RUN: in_ready=1. On beat with in_last -> DRAIN, drain counter=0.
  - DRAIN: in_ready=0, in_valid ignored. Counter increments each cycle. At count LAT-1 (the cycle of the final beat's out_valid slot), done=1 and -> IDLE.
  - Beat with in_last while IDLE: one-column frame, IDLE->DRAIN directly.
- Weights:
  - On w_valid: shadow shifts toward index 0; new bit enters index K*K-1. After K*K shifts, the first bit is k[0][0], row-major.
  - w_cnt saturates at K*K; w_full = (w_cnt==K*K). Extra bits keep shifting, so the last K*K bits are retained.
  - Weight loading is legal in any state and never disturbs the active bank.
  - w_commit with w_full=0: ignored.
  - w_commit with w_full=1 in IDLE: active<=shadow at next edge, w_cnt<=0.
  - w_commit with w_full=1 in RUN/DRAIN: set pending. The copy happens on the DRAIN->IDLE edge, so the whole frame uses one bank.
  - w_commit and w_valid in same cycle: the shift happens; commit evaluates pre-shift w_full.

Test Plan:
- Reset (K=5) -> in_ready=1; out_valid, done, w_full, out_data all 0; a frame with default weights of pixels all 1 gives 25.
- Load 25 ones, commit in IDLE, cfg_ni=28, 28 columns of pixel=1 (in_last on col 27) -> 24 results of 25. First out_valid 7 cycles after beat col 4. in_ready low 7 cycles. done pulses with last result.
- Alternating weights 1,0,1,... (13 plus, 12 minus), pixels all 3 -> every result 3. cfg_ni=12 -> exactly 8 results per row.
- Same frame with in_valid deasserted on every other cycle -> identical values and counts. Each result appears 7 cycles after its beat.
- Mid-RUN: load 25 zeros, commit -> rest of frame still 25. Next frame gives -25. w_full clears on the DRAIN->IDLE edge.
- DW=16, OW=16, weights all 1, pixels -32768 -> -32768 (sum -819200 saturated). Weights all 0, same pixels -> 32767. Assert rst mid-frame -> no done; next frame correct.
